// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator (640x480@60Hz by default) with renderer-latency compensation.
// Pixel coordinates go out combinationally; sync and colour leave through one aligned output register.
module vga_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIX_LAT  = 1
) (
  input  logic        vga_clk,
  input  logic        vga_rst,
  input  logic [11:0] pixel_data,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_start
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_ACT_C   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_LO = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_HI = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT_C   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SYNC_LO = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_HI = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);

  // Delay-line word layout: {active, hs_raw, vs_raw}; idle value keeps syncs deasserted.
  localparam logic [2:0] DLY_IDLE = 3'b011;

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic          active;
  logic          hs_raw;
  logic          vs_raw;
  logic [2:0]    dly [PIX_LAT];
  logic [2:0]    tail;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  // Raster counters: h every cycle, v on each line wrap.
  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + CW'(1);
    end else begin
      h_cnt <= h_cnt + CW'(1);
    end
  end

  always_comb begin
    active = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    hs_raw = !((h_cnt >= H_SYNC_LO) && (h_cnt < H_SYNC_HI));
    vs_raw = !((v_cnt >= V_SYNC_LO) && (v_cnt < V_SYNC_HI));
    x_pos  = active ? h_cnt : '0;
    y_pos  = active ? v_cnt : '0;
  end

  // Matches the renderer pipeline so decoded timing meets its pixel on the same edge.
  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      for (int i = 0; i < int'(PIX_LAT); i++) dly[i] <= DLY_IDLE;
    end else begin
      dly[0] <= {active, hs_raw, vs_raw};
      for (int i = 1; i < int'(PIX_LAT); i++) dly[i] <= dly[i-1];
    end
  end

  assign tail = dly[PIX_LAT-1];

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      hs          <= 1'b1;
      vs          <= 1'b1;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      frame_start <= 1'b0;
    end else begin
      hs          <= tail[1];
      vs          <= tail[0];
      vga_b       <= tail[2] ? pixel_data[11:8] : 4'h0;
      vga_g       <= tail[2] ? pixel_data[7:4]  : 4'h0;
      vga_r       <= tail[2] ? pixel_data[3:0]  : 4'h0;
      frame_start <= h_last && v_last;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized scoreboard bench for vga_timing_ctrl using a shrunken raster and a deeper renderer latency.
// Expected sync/colour per raster position is computed arithmetically from the cycle count since reset.
module tb_vga_timing_ctrl;

  localparam int HA = 20, HFP = 3, HSW = 4, HBP = 5;
  localparam int VA = 6,  VFP = 2, VSW = 2, VBP = 3;
  localparam int LAT = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  logic        clk = 1'b0;
  logic        vga_rst = 1'b1;
  logic [11:0] pixel_data = '0;
  logic [9:0]  x_pos, y_pos;
  logic        hs, vs, frame_start;
  logic [3:0]  vga_r, vga_g, vga_b;

  exp_t        sbq [$];
  logic [11:0] hist [$];
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;
  int          mode;

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .PIX_LAT(LAT)
  ) dut (
    .vga_clk(clk), .vga_rst(vga_rst), .pixel_data(pixel_data),
    .x_pos(x_pos), .y_pos(y_pos), .hs(hs), .vs(vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, expv, $time);
    end
  endtask

  function automatic bit is_active(input int n);
    int h, v;
    h = n % HT;
    v = (n / HT) % VT;
    return (h < HA) && (v < VA);
  endfunction

  // Renderer colour for the raster position reached n cycles after release.
  function automatic logic [11:0] colour(input int n);
    int h;
    h = n % HT;
    case (mode)
      0:       return 12'($urandom);
      1:       return is_active(n) ? 12'(h) : 12'h000;
      default: return 12'hFFF;
    endcase
  endfunction

  function automatic exp_t model(input int n, input logic [11:0] col);
    exp_t e;
    int h, v;
    h = n % HT;
    v = (n / HT) % VT;
    e.hs  = !((h >= HA + HFP) && (h < HA + HFP + HSW));
    e.vs  = !((v >= VA + VFP) && (v < VA + VFP + VSW));
    e.rgb = is_active(n) ? col : 12'h000;
    return e;
  endfunction

  // Per-cycle work for raster position n: direct checks, renderer feed, scoreboard push.
  task automatic step(input int n);
    logic [11:0] col;
    int h, v;
    h = n % HT;
    v = (n / HT) % VT;
    chk("x_pos", int'(x_pos), is_active(n) ? h : 0);
    chk("y_pos", int'(y_pos), is_active(n) ? v : 0);
    chk("frame_start", int'(frame_start), (n > 0 && (n % FT) == 0) ? 1 : 0);
    col = colour(n);
    hist.push_back(col);
    sbq.push_back(model(n, col));
    if (hist.size() > LAT) pixel_data = hist.pop_front();
    else pixel_data = 12'($urandom);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hs"}, int'(hs), 1);
    chk({tag, "_vs"}, int'(vs), 1);
    chk({tag, "_rgb"}, int'({vga_b, vga_g, vga_r}), 0);
    chk({tag, "_x"}, int'(x_pos), 0);
    chk({tag, "_y"}, int'(y_pos), 0);
    chk({tag, "_fs"}, int'(frame_start), 0);
  endtask

  // Monitor: one registered output word per clock edge while running.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 0, 1);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("hs", int'(hs), int'(e.hs));
        chk("vs", int'(vs), int'(e.vs));
        chk("rgb", int'({vga_b, vga_g, vga_r}), int'(e.rgb));
      end
    end
  end

  initial begin
    int n, run_len;
    repeat (3) @(posedge clk);
    #2;
    chk_reset_outputs("por");

    for (int ep = 0; ep < 5; ep++) begin
      // Release in the high phase, away from both edges.
      @(posedge clk);
      #2;
      mode = (ep < 3) ? ep : int'($urandom_range(0, 2));
      sbq.delete();
      hist.delete();
      vga_rst = 1'b0;
      for (int i = 0; i < LAT; i++) sbq.push_back(exp_t'({1'b1, 1'b1, 12'h000}));
      n = 0;
      step(n);

      run_len = FT + FT / 2 + int'($urandom_range(0, FT));
      if (ep == 4) run_len = 2 * FT + 5;
      for (int c = 0; c < run_len; c++) begin
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        n++;
        step(n);
      end

      // Asynchronous reset mid-line, held five cycles.
      #2;
      mon_en = 1'b0;
      vga_rst = 1'b1;
      pixel_data = 12'($urandom);
      #1;
      chk_reset_outputs("rst_async");
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        pixel_data = 12'($urandom);
        chk_reset_outputs("rst_hold");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
